// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit: instruction-memory request/response,
// redirect from execute, and the instruction hand-off to decode.
// master = the fetch unit, slave = its environment (memory + pipeline).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        fetch_misaligned;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc, opcode, fetch_misaligned,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, opcode, fetch_misaligned,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order word fetches,
// buffers returned words in a DEPTH-entry prefetch FIFO and hands them to
// decode with their PC. A redirect flushes the FIFO and drops every word
// that was granted before it.
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- a redirect to a target
// with nonzero low bits raises fetch_misaligned and stops fetching until an
// aligned redirect or reset. Without it the low target bits are ignored.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic          r_misaligned;
  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];

  logic          w_empty;
  logic          w_instr_valid;
  logic          w_pop;
  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_grant;
  logic          w_push;
  logic [31:0]   w_target;

  assign w_empty       = (r_count == '0);
  assign w_instr_valid = rst_n && !bus.redirect_valid && !w_empty;
  assign w_pop         = w_instr_valid && bus.instr_ready;
  // Slots already committed (buffered + in flight, stale ones included) after this cycle's pop
  assign w_used        = {1'b0, r_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);
  assign w_req         = rst_n && !bus.redirect_valid && !r_misaligned && (w_used < L_DEPTH);
  assign w_grant       = w_req && bus.imem_gnt;
  assign w_push        = rst_n && bus.imem_rvalid && !bus.redirect_valid && (r_discard == '0);

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_target = bus.redirect_pc;
`else
  assign w_target = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  assign bus.imem_req         = w_req;
  assign bus.imem_addr        = r_fetch_pc;
  assign bus.instr_valid      = w_instr_valid;
  assign bus.instr_out        = w_empty ? 32'h0 : r_instr_mem[r_rd_ptr];
  assign bus.instr_pc         = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];
  assign bus.opcode           = bus.instr_out[6:0];
  assign bus.fetch_misaligned = r_misaligned;

  // Control state: PCs, credit/discard counters, FIFO pointers, misalign flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_misaligned  <= 1'b0;
    end else if (bus.redirect_valid) begin
      // No grant is possible this cycle; everything still in flight is stale
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_outstanding <= r_outstanding - CW'(bus.imem_rvalid);
      r_discard     <= r_outstanding - CW'(bus.imem_rvalid);
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      r_misaligned  <= (bus.redirect_pc[1:0] != 2'b00);
`else
      r_misaligned  <= 1'b0;
`endif
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(bus.imem_rvalid);
      if (bus.imem_rvalid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO payload storage; not reset, outputs are masked while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: behavioural memory with random grant and
// latency, and a reference model of the delivered stream (sequential PCs
// from the last reset/redirect target, data = function of address).
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] exp_fetch, exp_pc, redir_first_pc;
  bit exp_mis = 1'b0;
  bit want_first = 1'b0;
  int grants_cnt = 0, pops_cnt = 0;
  int first_grant_cyc = -1, first_pop_cyc = -1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5C3_5A3B;
  endfunction

  // One clock cycle: drive inputs, observe transfers, advance the model
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] tgt, input int lat);
    bit rv;
    logic [31:0] w;
    @(negedge clk);
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_gnt       = gnt;
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    check_eq("misaligned", {31'd0, bus.fetch_misaligned}, {31'd0, exp_mis});
    if (redir) begin
      check_eq("req_in_redirect", {31'd0, bus.imem_req}, 32'd0);
      check_eq("valid_in_redirect", {31'd0, bus.instr_valid}, 32'd0);
    end
    if (exp_mis) check_eq("req_while_misaligned", {31'd0, bus.imem_req}, 32'd0);
    if (rv) void'(pend.pop_front());
    if (bus.imem_req && gnt) begin
      check_eq("fetch_addr", bus.imem_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      pend.push_back('{bus.imem_addr, cyc + lat});
      grants_cnt++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
    if (pend.size() > DEPTH) check_eq("credit", pend.size(), DEPTH);
    if (bus.instr_valid && rdy) begin
      w = mem_word(exp_pc);
      check_eq("instr_pc", bus.instr_pc, exp_pc);
      check_eq("instr_out", bus.instr_out, w);
      check_eq("opcode", {25'd0, bus.opcode}, {25'd0, w[6:0]});
      if (want_first) begin redir_first_pc = bus.instr_pc; want_first = 1'b0; end
      exp_pc = exp_pc + 32'd4;
      pops_cnt++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (redir) begin
`ifdef IFU_MISALIGN_CHECK_EN
      exp_mis   = (tgt[1:0] != 2'b00);
      exp_fetch = tgt;
      exp_pc    = tgt;
`else
      exp_fetch = tgt & 32'hFFFF_FFFC;
      exp_pc    = tgt & 32'hFFFF_FFFC;
`endif
      want_first = 1'b1;
      redir_first_pc = 32'hDEAD_BEEF;
    end
    cyc++;
  endtask

  initial begin
    int g0, p0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_eq("rst_instr_out", bus.instr_out, 32'd0);
    check_eq("rst_instr_pc", bus.instr_pc, 32'd0);
    check_eq("rst_opcode", {25'd0, bus.opcode}, 32'd0);
    check_eq("rst_misaligned", {31'd0, bus.fetch_misaligned}, 32'd0);

    // Release reset: request must appear in the very first cycle
    rst_n = 1'b1;
    #1;
    check_eq("first_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("first_addr", bus.imem_addr, RESET_PC);
    exp_fetch = RESET_PC; exp_pc = RESET_PC;
    cyc = 0; pend.delete();
    @(posedge clk);

    // Zero-wait memory streaming
    for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h0, 1);
    check_eq("first_valid_latency", first_pop_cyc - first_grant_cyc, 32'd2);
    check_eq("stream_throughput", pops_cnt, 32'd18);

    // Drain, then stall decode: exactly DEPTH grants before requests stop
    for (int i = 0; i < 8; i++) step(0, 1, 0, 32'h0, 1);
    g0 = grants_cnt;
    for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h0, 1);
    check_eq("stall_grants", grants_cnt - g0, DEPTH);
    check_eq("stall_req_low", {31'd0, bus.imem_req}, 32'd0);
    p0 = pops_cnt;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 32'h0, 1);
    check_eq("stall_release_pops", (pops_cnt - p0 >= DEPTH) ? 32'd1 : 32'd0, 32'd1);

    // 3-cycle latency memory, redirect with two words in flight
    for (int i = 0; i < 10 && pend.size() != 2; i++) step(1, 1, 0, 32'h0, 3);
    check_eq("lat3_outstanding", pend.size(), 32'd2);
    step(1, 1, 1, 32'h0000_0100, 3);
    for (int i = 0; i < 20 && want_first; i++) step(1, 1, 0, 32'h0, 3);
    check_eq("lat3_redirect_pc", redir_first_pc, 32'h0000_0100);

    // Redirect in zero-wait steady state (response and ready both active)
    for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 1);
    step(1, 1, 1, 32'h0000_2000, 1);
    for (int i = 0; i < 20 && want_first; i++) step(1, 1, 0, 32'h0, 1);
    check_eq("redir_rvalid_pc", redir_first_pc, 32'h0000_2000);

    // PC wrap-around
    step(1, 1, 1, 32'hFFFF_FFF8, 1);
    p0 = pops_cnt;
    for (int i = 0; i < 12; i++) step(1, 1, 0, 32'h0, 1);
    check_eq("wrap_first_pc", redir_first_pc, 32'hFFFF_FFF8);
    check_eq("wrap_progress", (pops_cnt - p0 >= 4) ? 32'd1 : 32'd0, 32'd1);

    // Misaligned redirect
    step(1, 1, 1, 32'h0000_0102, 1);
    g0 = grants_cnt;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0, 1);
`ifdef IFU_MISALIGN_CHECK_EN
    check_eq("mis_no_grants", grants_cnt - g0, 32'd0);
    check_eq("mis_flag", {31'd0, bus.fetch_misaligned}, 32'd1);
    step(1, 1, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 20 && want_first; i++) step(1, 1, 0, 32'h0, 1);
    check_eq("mis_resume_pc", redir_first_pc, 32'h0000_0200);
    check_eq("mis_cleared", {31'd0, bus.fetch_misaligned}, 32'd0);
`else
    check_eq("nomis_resume_pc", redir_first_pc, 32'h0000_0100);
    check_eq("nomis_flag", {31'd0, bus.fetch_misaligned}, 32'd0);
`endif

    // Randomized traffic
    p0 = pops_cnt;
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      logic [31:0] t;
      rd = ($urandom_range(0, 29) == 0);
      t  = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, t,
           int'($urandom_range(1, 4)));
    end
    check_eq("random_progress", (pops_cnt - p0 > 500) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end: owns the program counter, issues in-order word fetches to instruction memory, buffers returned words in a small prefetch FIFO, and presents them with their PC to the decode stage (control unit via `opcode`). It accepts a redirect (taken branch, JAL, JALR) from execute that flushes buffered and in-flight instructions and restarts fetch at the target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, prefetch FIFO entries; power of two, ≥2; also the max in-flight + buffered count

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `imem_req`  out  1  fetch request valid; transfer when `imem_req && imem_gnt`
- `imem_addr`  out  32  word-aligned fetch address
- `imem_gnt`  in  1  memory accepts the request this cycle
- `imem_rvalid`  in  1  read data valid; in order, ≥1 cycle after grant
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  one-cycle pulse, restart fetch
- `redirect_pc`  in  32  restart target
- `instr_valid`  out  1  instruction available to decode
- `instr_ready`  in  1  decode accepts; pop on `instr_valid && instr_ready`
- `instr_out`  out  32  FIFO head instruction
- `instr_pc`  out  32  PC of `instr_out`
- `opcode`  out  7  `instr_out[6:0]`, to control unit
- `fetch_misaligned`  out  1  misaligned redirect flag (see Configuration)

## Operation
- Registers: `fetch_pc` (next request address), `resp_pc` (PC of next kept response), `outstanding` (granted, not returned), `discard` (stale in-flight to drop), FIFO with `count`, `fetch_misaligned`.
- Reset (`rst_n`=0 at edge): `fetch_pc`=`resp_pc`=`RESET_PC`, `outstanding`=`discard`=`count`=0, `fetch_misaligned`=0. During reset `imem_req`=0 and `instr_valid`=0; `instr_out`, `instr_pc`, `opcode` = 0 while FIFO empty.
- Request: `imem_req` = `!redirect_valid && !fetch_misaligned && (count + outstanding − pop) < DEPTH`, pop = this cycle's dequeue; `imem_addr` = `fetch_pc`. Request need not be held; memory samples per cycle.
- Grant: `fetch_pc` += 4 (mod 2^32, wraps), `outstanding` += 1.
- Response: `outstanding` −= 1. If `discard`>0: drop word, `discard` −= 1. Else push {`imem_rdata`, `resp_pc`}, `resp_pc` += 4.
- Credit rule guarantees a push never hits a full FIFO; simultaneous push and pop leaves `count` unchanged; push and pop on empty FIFO do not bypass (push visible next cycle).
- Redirect: `instr_valid` forced 0 that cycle (no pop); next edge: FIFO flushed (`count`=0), `fetch_pc`=`resp_pc`=target, `discard` = `outstanding` + `discard`-adjusted so every request granted before the redirect is dropped, i.e. `discard` ← `outstanding` − `imem_rvalid`. A response arriving in the redirect cycle is dropped. Back-to-back redirects: last one wins; all earlier in-flight still discarded.

## Timing
- Zero-wait memory (gnt same cycle, rvalid next): first `imem_req` in the first cycle after reset release; `instr_valid` two cycles after first grant.
- Sustained throughput 1 instruction/cycle with `instr_ready`=1 and `DEPTH`≥2.
- Redirect-to-first-new-request: 1 cycle (request issued in cycle after pulse, if credit available; stale in-flight still consume credit until returned).
- `instr_*` outputs driven directly from FIFO head registers; no combinational path from `imem_rdata`.

## Configuration
- `IFU_MISALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0]`≠0 sets `fetch_misaligned` at next edge, flushes as normal, and blocks all requests; stale responses still drained. Cleared only by an aligned redirect or reset.
- Not defined: `redirect_pc[1:0]` ignored (treated as 2'b00); `fetch_misaligned` tied 0.

## Test plan
- Reset, zero-wait memory, `instr_ready`=1: addresses 0x0,0x4,0x8… granted each cycle; `instr_pc` 0x0,0x4,0x8 on consecutive cycles from cycle 2.
- `instr_ready`=0 for 10 cycles: exactly `DEPTH` grants issued, then `imem_req`=0; release ready → instructions delivered in order, no loss/duplication.
- Memory with 3-cycle rvalid latency, 2 outstanding, redirect to 0x100: both stale words dropped; first delivered `instr_pc`=0x100 with data from 0x100.
- Redirect coinciding with `imem_rvalid` and `instr_ready`: no pop that cycle, returning word dropped, next delivered PC = target.
- `fetch_pc`=0xFFFF_FFFC: next fetch address wraps to 0x0000_0000, `instr_pc` sequence ...FFFC, 0000.
- With `IFU_MISALIGN_CHECK_EN`, redirect to 0x102: `fetch_misaligned`=1, no requests; redirect to 0x200 clears it, fetch resumes at 0x200. Without macro: fetch resumes at 0x100.
